// File: rtl/alu_pkg.sv
// alu_pkg: opcodes, FSM states and exception causes shared by the
// sequential ALU and its iterative multiply/divide unit.
package alu_pkg;

  localparam logic [4:0] OP_ADD = 5'b00000;
  localparam logic [4:0] OP_SUB = 5'b00001;
  localparam logic [4:0] OP_AND = 5'b00010;
  localparam logic [4:0] OP_OR  = 5'b00011;
  localparam logic [4:0] OP_SLL = 5'b00100;
  localparam logic [4:0] OP_SRA = 5'b00101;
  localparam logic [4:0] OP_MUL = 5'b00110;
  localparam logic [4:0] OP_DIV = 5'b00111;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_BUSY = 2'd1,
    S_DONE = 2'd2
  } state_e;

  typedef enum logic [1:0] {
    EXC_NONE    = 2'd0,
    EXC_OVF     = 2'd1,
    EXC_DIV0    = 2'd2,
    EXC_ILLEGAL = 2'd3
  } exc_e;

endpackage

// File: rtl/alu_seq_multdiv.sv
// multdiv_iter: one-bit-per-cycle shift-add multiply and restoring
// divide on magnitudes; sign fix-up is folded into the final cycle.
module multdiv_iter #(
  parameter int WIDTH = 32
) (
  input  logic             clock,
  input  logic             reset_n,
  input  logic             start,
  input  logic             is_div,
  input  logic [WIDTH-1:0] op_a,
  input  logic [WIDTH-1:0] op_b,
  output logic             done,
  output logic [WIDTH-1:0] result,
  output logic             exception
);
  localparam int CW = $clog2(WIDTH);

  logic               busy_q, div_q, neg_q, bz_q;
  logic [CW-1:0]      cnt_q;
  logic [WIDTH-1:0]   opnd_q;
  logic [2*WIDTH-1:0] acc_q, acc_d;
  logic [WIDTH-1:0]   ma, mb, hi, lo, mag;
  logic [WIDTH:0]     msum, trial;
  logic               p_hi_z;

  assign ma = op_a[WIDTH-1] ? -op_a : op_a;
  assign mb = op_b[WIDTH-1] ? -op_b : op_b;
  assign {hi, lo} = acc_q;

  assign msum  = {1'b0, hi}
               + (lo[0] ? {1'b0, opnd_q} : '0);
  assign trial = {hi, lo[WIDTH-1]}
               - {1'b0, opnd_q};

  // div: {remainder, quotient}; mul: {partial product, multiplier}
  always_comb begin
    acc_d = {msum, lo[WIDTH-1:1]};
    if (div_q) begin
      if (trial[WIDTH])
        acc_d = {hi[WIDTH-2:0], lo, 1'b0};
      else
        acc_d = {trial[WIDTH-1:0],
                 lo[WIDTH-2:0], 1'b1};
    end
  end

  assign done   = busy_q && (cnt_q == CW'(WIDTH - 1));
  assign mag    = acc_d[WIDTH-1:0];
  assign p_hi_z = ~|acc_d[2*WIDTH-1:WIDTH];

  always_comb begin
    result    = neg_q ? -mag : mag;
    exception = 1'b0;
    if (div_q) begin
      exception = bz_q | (~neg_q & mag[WIDTH-1]);
      if (bz_q) result = '0;
    end else if (!p_hi_z) begin
      exception = 1'b1;
    end else if (neg_q) begin
      exception = mag[WIDTH-1] & (|mag[WIDTH-2:0]);
    end else begin
      exception = mag[WIDTH-1];
    end
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      busy_q <= 1'b0;
      div_q  <= 1'b0;
      neg_q  <= 1'b0;
      bz_q   <= 1'b0;
      cnt_q  <= '0;
      opnd_q <= '0;
      acc_q  <= '0;
    end else if (start) begin
      busy_q <= 1'b1;
      div_q  <= is_div;
      neg_q  <= op_a[WIDTH-1] ^ op_b[WIDTH-1];
      bz_q   <= ~|op_b;
      cnt_q  <= '0;
      opnd_q <= is_div ? mb : ma;
      acc_q  <= {{WIDTH{1'b0}}, is_div ? ma : mb};
    end else if (busy_q) begin
      acc_q <= acc_d;
      cnt_q <= cnt_q + 1'b1;
      if (done) busy_q <= 1'b0;
    end
  end

endmodule

// File: rtl/alu_seq.sv
// alu_seq: registered multicycle ALU with valid/ready handshakes.
// Single-cycle ops finish in one cycle; MUL/DIV run in multdiv_iter.
module alu_seq #(
  parameter int  WIDTH = 32,
  localparam int SHW   = $clog2(WIDTH)
) (
  input  logic             clock,
  input  logic             reset_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [4:0]       ctrl_ALUopcode,
  input  logic [SHW-1:0]   ctrl_shiftamt,
  input  logic [WIDTH-1:0] data_operandA,
  input  logic [WIDTH-1:0] data_operandB,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] data_result,
  output logic             data_exception,
  output logic             isNotEqual,
  output logic             isLessThan
);
  import alu_pkg::*;

  state_e           state_q, state_d;
  exc_e             cause_q, alu_cause;
  logic [WIDTH-1:0] result_q, alu_res, add_r, sub_r, md_res;
  logic             ne_q, lt_q, ne_p_q, lt_p_q, div0_p_q;
  logic             add_ovf, sub_ovf, ne, lt, is_md;
  logic             accept, md_start, load_alu, load_md;
  logic             md_done, md_exc;

  assign add_r = data_operandA + data_operandB;
  assign sub_r = data_operandA - data_operandB;
  assign add_ovf =
    (data_operandA[WIDTH-1] == data_operandB[WIDTH-1])
    && (add_r[WIDTH-1] != data_operandA[WIDTH-1]);
  assign sub_ovf =
    (data_operandA[WIDTH-1] != data_operandB[WIDTH-1])
    && (sub_r[WIDTH-1] != data_operandA[WIDTH-1]);
  assign ne = |(data_operandA ^ data_operandB);
  assign lt = sub_r[WIDTH-1] ^ sub_ovf;

  always_comb begin
    alu_res   = '0;
    alu_cause = EXC_ILLEGAL;
    is_md     = 1'b0;
    unique case (ctrl_ALUopcode)
      OP_ADD: begin
        alu_res   = add_r;
        alu_cause = add_ovf ? EXC_OVF : EXC_NONE;
      end
      OP_SUB: begin
        alu_res   = sub_r;
        alu_cause = sub_ovf ? EXC_OVF : EXC_NONE;
      end
      OP_AND: begin
        alu_res   = data_operandA & data_operandB;
        alu_cause = EXC_NONE;
      end
      OP_OR: begin
        alu_res   = data_operandA | data_operandB;
        alu_cause = EXC_NONE;
      end
      OP_SLL: begin
        alu_res   = data_operandA << ctrl_shiftamt;
        alu_cause = EXC_NONE;
      end
      OP_SRA: begin
        alu_res   = $signed(data_operandA)
                    >>> ctrl_shiftamt;
        alu_cause = EXC_NONE;
      end
      OP_MUL, OP_DIV: begin
        alu_cause = EXC_NONE;
        is_md     = 1'b1;
      end
      default: ;
    endcase
  end

  always_comb begin
    state_d  = state_q;
    accept   = 1'b0;
    md_start = 1'b0;
    load_alu = 1'b0;
    load_md  = 1'b0;
    unique case (state_q)
      S_IDLE: if (in_valid) begin
        accept = 1'b1;
        if (is_md) begin
          md_start = 1'b1;
          state_d  = S_BUSY;
        end else begin
          load_alu = 1'b1;
          state_d  = S_DONE;
        end
      end
      S_BUSY: if (md_done) begin
        load_md = 1'b1;
        state_d = S_DONE;
      end
      S_DONE: if (out_ready) state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  multdiv_iter #(.WIDTH(WIDTH)) u_md (
    .clock     (clock),
    .reset_n   (reset_n),
    .start     (md_start),
    .is_div    (ctrl_ALUopcode == OP_DIV),
    .op_a      (data_operandA),
    .op_b      (data_operandB),
    .done      (md_done),
    .result    (md_res),
    .exception (md_exc)
  );

  // flags of a MUL/DIV are held until its result lands
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state_q  <= S_IDLE;
      cause_q  <= EXC_NONE;
      result_q <= '0;
      ne_q     <= 1'b0;
      lt_q     <= 1'b0;
      ne_p_q   <= 1'b0;
      lt_p_q   <= 1'b0;
      div0_p_q <= 1'b0;
    end else begin
      state_q <= state_d;
      if (accept) begin
        ne_p_q   <= ne;
        lt_p_q   <= lt;
        div0_p_q <= (ctrl_ALUopcode == OP_DIV)
                    && ~|data_operandB;
      end
      if (load_alu) begin
        result_q <= alu_res;
        cause_q  <= alu_cause;
        ne_q     <= ne;
        lt_q     <= lt;
      end else if (load_md) begin
        result_q <= md_res;
        cause_q  <= !md_exc  ? EXC_NONE :
                    div0_p_q ? EXC_DIV0 : EXC_OVF;
        ne_q     <= ne_p_q;
        lt_q     <= lt_p_q;
      end
    end
  end

  assign in_ready       = (state_q == S_IDLE);
  assign out_valid      = (state_q == S_DONE);
  assign data_result    = result_q;
  assign data_exception = (cause_q != EXC_NONE);
  assign isNotEqual     = ne_q;
  assign isLessThan     = lt_q;

endmodule
